// File: rtl/snn_timestep_scheduler_pkg.sv
// Shared types and defaults for the SNN timestep scheduler: FSM state encoding,
// default layer geometry and the neuron-index width helper.
package snn_timestep_scheduler_pkg;

  localparam int DEF_N_NEURONS   = 2;
  localparam int DEF_W           = 8;
  localparam int DEF_TICK_PERIOD = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_COMMIT = 3'd4
  } sched_state_t;

  // A single-neuron layer still needs a 1-bit index bus.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snn_timestep_scheduler_if.sv
// Request/response channel between the scheduler (master) and the external LIF core (slave).
// One outstanding request: valid/ready request, single-cycle response pulse.
interface snn_timestep_scheduler_if
  import snn_timestep_scheduler_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int W         = DEF_W
);
  localparam int IDXW = idx_width(N_NEURONS);

  logic            core_req_valid;
  logic            core_req_ready;
  logic [IDXW-1:0] core_req_idx;
  logic [W-1:0]    core_req_cur;
  logic [W-1:0]    core_req_mem;
  logic            core_rsp_valid;
  logic [W-1:0]    core_rsp_mem;
  logic            core_rsp_spike;

  modport master (
    output core_req_valid, core_req_idx, core_req_cur, core_req_mem,
    input  core_req_ready, core_rsp_valid, core_rsp_mem, core_rsp_spike
  );

  modport slave (
    input  core_req_valid, core_req_idx, core_req_cur, core_req_mem,
    output core_req_ready, core_rsp_valid, core_rsp_mem, core_rsp_spike
  );

endinterface

// File: rtl/snn_timestep_scheduler_tick_timer.sv
// Timestep tick source: free-running wrap counter (held at 0 while disabled) OR'd with step_req.
// Tick is combinational in the wrap/request cycle; no backpressure, the consumer decides whether to drop it.
module snn_timestep_scheduler_tick_timer
  import snn_timestep_scheduler_pkg::*;
#(
  parameter int TICK_PERIOD = DEF_TICK_PERIOD
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_step_req,
  output logic o_tick
);

  localparam int CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TICK_PERIOD - 1);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = i_enable && (r_count == LAST_COUNT);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (!i_enable || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // A wrap and a manual request in the same cycle collapse into one tick.
  assign o_tick = w_wrap | i_step_req;

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Walks neurons 0..N-1 through one shared external LIF core per tick and commits spikes/membranes.
// Latency tick->step_done = 2+2*N cycles plus core latency; stalls in ISSUE on core_req_ready, ticks while busy are dropped.
module snn_timestep_scheduler
  import snn_timestep_scheduler_pkg::*;
#(
  parameter int N_NEURONS   = DEF_N_NEURONS,
  parameter int W           = DEF_W,
  parameter int TICK_PERIOD = DEF_TICK_PERIOD
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_step_req,
  input  logic [N_NEURONS*W-1:0]   i_cur_in,
  snn_timestep_scheduler_if.master core,
  output logic [N_NEURONS-1:0]     o_spike_vec,
  output logic [N_NEURONS*W-1:0]   o_state_vec,
  output logic                     o_step_done,
  output logic                     o_busy,
  output logic                     o_overrun
);

  localparam int IDXW = idx_width(N_NEURONS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NEURONS - 1);

  sched_state_t           r_state;
  logic [IDXW-1:0]        r_idx;
  logic [W-1:0]           r_cur [N_NEURONS];
  logic [W-1:0]           r_mem [N_NEURONS];
  logic [N_NEURONS-1:0]   r_spike_next;
  logic [N_NEURONS-1:0]   r_spike_vec;
  logic [N_NEURONS*W-1:0] r_state_vec;
  logic                   r_req_valid;
  logic                   r_step_done;
  logic                   r_busy;
  logic                   r_overrun;
  logic                   w_tick;

  snn_timestep_scheduler_tick_timer #(
    .TICK_PERIOD (TICK_PERIOD)
  ) u_tick_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_step_req (i_step_req),
    .o_tick     (w_tick)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_spike_next <= '0;
      r_spike_vec  <= '0;
      r_state_vec  <= '0;
      r_req_valid  <= 1'b0;
      r_step_done  <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_cur[i] <= '0;
        r_mem[i] <= '0;
      end
    end else begin
      r_step_done <= 1'b0;

      // Any tick outside IDLE, including the COMMIT cycle itself, is lost.
      if (w_tick && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end
        end

        ST_LOAD: begin
          for (int i = 0; i < N_NEURONS; i++) begin
            r_cur[i] <= i_cur_in[i*W +: W];
          end
          r_idx        <= '0;
          r_spike_next <= '0;
          r_req_valid  <= 1'b1;
          r_state      <= ST_ISSUE;
        end

        ST_ISSUE: begin
          if (core.core_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (core.core_rsp_valid) begin
            r_mem[r_idx]        <= core.core_rsp_mem;
            r_spike_next[r_idx] <= core.core_rsp_spike;
            if (r_idx == LAST_IDX) begin
              r_step_done <= 1'b1;
              r_state     <= ST_COMMIT;
            end else begin
              r_idx       <= r_idx + 1'b1;
              r_req_valid <= 1'b1;
              r_state     <= ST_ISSUE;
            end
          end
        end

        ST_COMMIT: begin
          r_spike_vec <= r_spike_next;
          for (int i = 0; i < N_NEURONS; i++) begin
            r_state_vec[i*W +: W] <= r_mem[i];
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Request fields come straight from registers that do not move while in ISSUE.
  assign core.core_req_valid = r_req_valid;
  assign core.core_req_idx   = r_idx;
  assign core.core_req_cur   = r_cur[r_idx];
  assign core.core_req_mem   = r_mem[r_idx];

  assign o_spike_vec = r_spike_vec;
  assign o_state_vec = r_state_vec;
  assign o_step_done = r_step_done;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Bench for snn_timestep_scheduler: behavioural LIF core (mem' = cur + mem, spike = mem' >= threshold)
// plus a per-neuron membrane model advanced once per committed timestep.
`timescale 1ns/1ps
module tb_snn_timestep_scheduler;
  import snn_timestep_scheduler_pkg::*;

  localparam int N    = 2;
  localparam int W    = 8;
  localparam int TP   = 16;
  localparam int VW   = N * W;
  localparam int IDXW = idx_width(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          step_req = 1'b0;
  logic [VW-1:0] cur_in = '0;
  logic [N-1:0]  spike_vec;
  logic [VW-1:0] state_vec;
  logic          step_done, busy, overrun;

  snn_timestep_scheduler_if #(.N_NEURONS(N), .W(W)) core_if ();

  snn_timestep_scheduler #(.N_NEURONS(N), .W(W), .TICK_PERIOD(TP)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_enable    (enable),
    .i_step_req  (step_req),
    .i_cur_in    (cur_in),
    .core        (core_if),
    .o_spike_vec (spike_vec),
    .o_state_vec (state_vec),
    .o_step_done (step_done),
    .o_busy      (busy),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int done_cnt = 0;

  // core model knobs and observations
  int  rsp_lat = 0;
  int  stall_per_req = 0;
  int  spike_thresh = 256;
  bit  spurious_en = 1'b0;
  int  hs_cnt = 0;
  int  hs_idx[$];
  int  stall_seen = 0;
  int  unstable = 0;

  // reference model state
  int            exp_mem [N];
  logic [VW-1:0] exp_state = '0;
  logic [N-1:0]  exp_spike = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (step_done === 1'b1) done_cnt++;
  end

  // Behavioural core: responds rsp_lat cycles after the WAIT cycle begins.
  bit              c_pend = 1'b0;
  int              c_cnt = 0;
  int              c_stall = 0;
  bit              c_seen = 1'b0;
  logic [W-1:0]    c_mem, c_sum;
  logic            c_spk;
  logic [IDXW-1:0] s_idx;
  logic [W-1:0]    s_cur, s_mem;
  initial begin
    core_if.core_req_ready = 1'b1;
    core_if.core_rsp_valid = 1'b0;
    core_if.core_rsp_mem   = '0;
    core_if.core_rsp_spike = 1'b0;
    forever begin
      @(negedge clk);
      core_if.core_rsp_valid = 1'b0;
      if (!rst_n) begin
        c_pend = 1'b0; c_stall = 0; c_seen = 1'b0;
        core_if.core_req_ready = 1'b1;
      end else begin
        if (c_pend) begin
          if (c_cnt == 0) begin
            core_if.core_rsp_valid = 1'b1;
            core_if.core_rsp_mem   = c_mem;
            core_if.core_rsp_spike = c_spk;
            c_pend = 1'b0;
          end else c_cnt--;
        end else if (spurious_en && $urandom_range(2) == 0) begin
          core_if.core_rsp_valid = 1'b1;
          core_if.core_rsp_mem   = W'($urandom);
          core_if.core_rsp_spike = 1'b1;
        end
        if (core_if.core_req_valid === 1'b1) begin
          if (!c_seen) begin
            c_seen = 1'b1; c_stall = stall_per_req;
            s_idx = core_if.core_req_idx; s_cur = core_if.core_req_cur; s_mem = core_if.core_req_mem;
          end else if (core_if.core_req_idx !== s_idx || core_if.core_req_cur !== s_cur ||
                       core_if.core_req_mem !== s_mem) begin
            unstable++;
          end
          if (c_stall > 0) begin
            core_if.core_req_ready = 1'b0; c_stall--; stall_seen++;
          end else begin
            core_if.core_req_ready = 1'b1; c_seen = 1'b0; hs_cnt++;
            hs_idx.push_back(int'(core_if.core_req_idx));
            c_sum = core_if.core_req_cur + core_if.core_req_mem;
            c_mem = c_sum; c_spk = (int'(c_sum) >= spike_thresh);
            c_pend = 1'b1; c_cnt = rsp_lat;
          end
        end else begin
          core_if.core_req_ready = 1'b1;
        end
      end
    end
  end

  function automatic void model_clear();
    for (int i = 0; i < N; i++) exp_mem[i] = 0;
    exp_state = '0;
    exp_spike = '0;
  endfunction

  function automatic void model_step(input logic [VW-1:0] cur);
    int s;
    for (int i = 0; i < N; i++) begin
      s = (exp_mem[i] + int'(cur[i*W +: W])) % (1 << W);
      exp_mem[i] = s;
      exp_state[i*W +: W] = W'(s);
      exp_spike[i] = (s >= spike_thresh);
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic tick_pulse(output int t0);
    @(negedge clk);
    step_req = 1'b1;
    t0 = cyc;
    @(negedge clk);
    step_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int at);
    ok = 1'b0; at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (step_done === 1'b1) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      step_req = (i % 3 == 0);
      if (core_if.core_req_valid !== 1'b0 || busy !== 1'b0 || step_done !== 1'b0 ||
          overrun !== 1'b0 || spike_vec !== '0 || state_vec !== '0) bad++;
    end
    step_req = 1'b0; enable = 1'b0;
    checks++; if (bad !== 0) $display("FAIL reset_hold: %0d cycles with nonzero outputs, want 0", bad); else passed++;
    checks++; if (state_vec !== '0) $display("FAIL reset_state_vec: got %h want 0", state_vec); else passed++;
    checks++; if (spike_vec !== '0) $display("FAIL reset_spike_vec: got %b want 0", spike_vec); else passed++;
    checks++; if (core_if.core_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", core_if.core_req_valid); else passed++;
    rst_n = 1'b1;
    model_clear();
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b0 || overrun !== 1'b0) $display("FAIL post_reset_idle: busy=%b overrun=%b want 0/0", busy, overrun); else passed++;
  endtask

  task automatic test_single_step();
    int t0, at, d0, h0; bit ok;
    rsp_lat = 0; stall_per_req = 0; spike_thresh = 256;
    cur_in = {8'd20, 8'd10};
    hs_idx.delete(); h0 = hs_cnt; d0 = done_cnt;
    tick_pulse(t0);
    checks++; if (busy !== 1'b1 || core_if.core_req_valid !== 1'b0) $display("FAIL load_cycle: busy=%b valid=%b want 1/0", busy, core_if.core_req_valid); else passed++;
    wait_done(40, ok, at);
    checks++; if (ok !== 1'b1) $display("FAIL single_done_timeout: step_done not seen, want pulse"); else passed++;
    checks++; if (at - t0 !== 6) $display("FAIL single_latency: got %0d want 6", at - t0); else passed++;
    model_step(cur_in);
    @(negedge clk);
    checks++; if (state_vec !== exp_state) $display("FAIL single_state_vec: got %h want %h", state_vec, exp_state); else passed++;
    checks++; if (state_vec !== 16'h140A) $display("FAIL single_state_literal: got %h want 140a", state_vec); else passed++;
    checks++; if (spike_vec !== 2'b00 || busy !== 1'b0) $display("FAIL single_spike_busy: spike=%b busy=%b want 00/0", spike_vec, busy); else passed++;
    repeat (10) @(posedge clk);
    checks++; if (done_cnt - d0 !== 1) $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); else passed++;
    checks++; if (hs_cnt - h0 !== 2 || hs_idx.size() !== 2) $display("FAIL single_handshakes: got %0d want 2", hs_cnt - h0); else passed++;
    if (hs_idx.size() == 2) begin
      checks++; if (hs_idx[0] !== 0 || hs_idx[1] !== 1) $display("FAIL single_idx_order: got %0d,%0d want 0,1", hs_idx[0], hs_idx[1]); else passed++;
    end
  endtask

  task automatic test_backpressure();
    int t0, at, d0, h0; bit ok;
    do_reset();
    stall_per_req = 5; stall_seen = 0; unstable = 0;
    cur_in = {8'd20, 8'd10};
    h0 = hs_cnt; d0 = done_cnt;
    tick_pulse(t0);
    wait_done(80, ok, at);
    checks++; if (ok !== 1'b1) $display("FAIL bp_done_timeout: step_done not seen, want pulse"); else passed++;
    checks++; if (at - t0 !== 16) $display("FAIL bp_latency: got %0d want 16", at - t0); else passed++;
    model_step(cur_in);
    @(negedge clk);
    checks++; if (state_vec !== exp_state || spike_vec !== exp_spike) $display("FAIL bp_result: got %h/%b want %h/%b", state_vec, spike_vec, exp_state, exp_spike); else passed++;
    repeat (10) @(posedge clk);
    checks++; if (unstable !== 0) $display("FAIL bp_stability: got %0d changes want 0", unstable); else passed++;
    checks++; if (stall_seen !== 10) $display("FAIL bp_stall_cycles: got %0d want 10", stall_seen); else passed++;
    checks++; if (hs_cnt - h0 !== 2 || done_cnt - d0 !== 1) $display("FAIL bp_counts: hs=%0d done=%0d want 2/1", hs_cnt - h0, done_cnt - d0); else passed++;
    stall_per_req = 0;
  endtask

  task automatic test_overrun();
    int t0, at, d0; bit ok;
    do_reset();
    cur_in = {8'd5, 8'd9};
    d0 = done_cnt;
    tick_pulse(t0);
    wait_done(40, ok, at);
    step_req = 1'b1;
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_before: got %b want 0", overrun); else passed++;
    @(negedge clk);
    step_req = 1'b0;
    checks++; if (overrun !== 1'b1 || busy !== 1'b0) $display("FAIL ovr_commit_tick: overrun=%b busy=%b want 1/0", overrun, busy); else passed++;
    model_step(cur_in);
    checks++; if (state_vec !== exp_state) $display("FAIL ovr_commit_state: got %h want %h", state_vec, exp_state); else passed++;
    repeat (20) @(posedge clk);
    checks++; if (done_cnt - d0 !== 1) $display("FAIL ovr_commit_done_count: got %0d want 1", done_cnt - d0); else passed++;

    do_reset();
    @(negedge clk);
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_reset_clears: got %b want 0", overrun); else passed++;
    d0 = done_cnt;
    tick_pulse(t0);
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    checks++; if (overrun !== 1'b1 || busy !== 1'b1) $display("FAIL ovr_busy_tick: overrun=%b busy=%b want 1/1", overrun, busy); else passed++;
    wait_done(40, ok, at);
    checks++; if (ok !== 1'b1) $display("FAIL ovr_done_timeout: step_done not seen, want pulse"); else passed++;
    repeat (20) @(posedge clk);
    checks++; if (done_cnt - d0 !== 1) $display("FAIL ovr_busy_done_count: got %0d want 1", done_cnt - d0); else passed++;
    tick_pulse(t0);
    wait_done(40, ok, at);
    @(negedge clk);
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else passed++;
  endtask

  task automatic test_auto_tick();
    int e, at, prev, d0; bit ok;
    do_reset();
    rsp_lat = 0; spike_thresh = 12;
    cur_in = {8'd7, 8'd3};
    @(negedge clk);
    enable = 1'b1; e = cyc;
    wait_done(40, ok, at);
    checks++; if (!ok || at - e !== 21) $display("FAIL auto_first: ok=%b delay=%0d want 1/21", ok, at - e); else passed++;
    model_step(cur_in);
    for (int k = 1; k < 5; k++) begin
      prev = at;
      wait_done(40, ok, at);
      checks++; if (!ok || at - prev !== TP) $display("FAIL auto_period_%0d: ok=%b got %0d want %0d", k, ok, at - prev, TP); else passed++;
      model_step(cur_in);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (state_vec !== exp_state || spike_vec !== exp_spike) $display("FAIL auto_result: got %h/%b want %h/%b", state_vec, spike_vec, exp_state, exp_spike); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL auto_no_overrun: got %b want 0", overrun); else passed++;
    @(posedge clk);
    d0 = done_cnt;
    repeat (60) @(posedge clk);
    checks++; if (done_cnt !== d0 || busy !== 1'b0) $display("FAIL auto_disabled: extra=%0d busy=%b want 0/0", done_cnt - d0, busy); else passed++;
    @(negedge clk);
    enable = 1'b1; e = cyc;
    wait_done(40, ok, at);
    enable = 1'b0;
    checks++; if (!ok || at - e !== 21) $display("FAIL auto_timer_restart: ok=%b delay=%0d want 1/21", ok, at - e); else passed++;
    model_step(cur_in);
    @(negedge clk);
    checks++; if (state_vec !== exp_state) $display("FAIL auto_restart_state: got %h want %h", state_vec, exp_state); else passed++;
  endtask

  task automatic test_reset_mid_step();
    int t0, at, d0, h0, n; bit ok;
    do_reset();
    rsp_lat = 3; spike_thresh = 100;
    cur_in = {8'd150, 8'd40};
    tick_pulse(t0);
    wait_done(60, ok, at);
    model_step(cur_in);
    @(negedge clk);
    checks++; if (state_vec !== exp_state || spike_vec !== exp_spike) $display("FAIL mid_pre_step: got %h/%b want %h/%b", state_vec, spike_vec, exp_state, exp_spike); else passed++;
    h0 = hs_cnt;
    tick_pulse(t0);
    n = 0;
    while (hs_cnt < h0 + 2 && n < 60) begin @(posedge clk); n++; end
    checks++; if (hs_cnt < h0 + 2) $display("FAIL mid_wait_timeout: handshakes %0d want 2", hs_cnt - h0); else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || core_if.core_req_valid !== 1'b0 || step_done !== 1'b0) $display("FAIL mid_abort_ctrl: busy=%b valid=%b done=%b want 0", busy, core_if.core_req_valid, step_done); else passed++;
    checks++; if (state_vec !== '0 || spike_vec !== '0) $display("FAIL mid_abort_vec: got %h/%b want 0/0", state_vec, spike_vec); else passed++;
    @(posedge clk);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (20) @(posedge clk);
    checks++; if (done_cnt !== d0) $display("FAIL mid_no_done: got %0d extra want 0", done_cnt - d0); else passed++;
    rsp_lat = 0;
    cur_in = {8'd33, 8'd77};
    tick_pulse(t0);
    wait_done(40, ok, at);
    model_step(cur_in);
    @(negedge clk);
    checks++; if (!ok || state_vec !== exp_state) $display("FAIL mid_fresh_step: ok=%b got %h want %h", ok, state_vec, exp_state); else passed++;
  endtask

  task automatic test_back_to_back();
    int t0, at, h0, bad; bit ok;
    logic [VW-1:0] cur_s;
    do_reset();
    spurious_en = 1'b1; unstable = 0;
    hs_idx.delete(); h0 = hs_cnt; bad = 0;
    for (int s = 0; s < 8; s++) begin
      cur_s = VW'($urandom);
      cur_in = cur_s;
      stall_per_req = $urandom_range(3);
      rsp_lat = $urandom_range(2);
      spike_thresh = $urandom_range(64, 200);
      tick_pulse(t0);
      @(negedge clk);
      cur_in = VW'($urandom);
      if (state_vec !== exp_state) bad++;
      model_step(cur_s);
      wait_done(60, ok, at);
      @(negedge clk);
      checks++; if (!ok || state_vec !== exp_state) $display("FAIL b2b_state_%0d: ok=%b got %h want %h", s, ok, state_vec, exp_state); else passed++;
      checks++; if (spike_vec !== exp_spike) $display("FAIL b2b_spike_%0d: got %b want %b", s, spike_vec, exp_spike); else passed++;
    end
    spurious_en = 1'b0; stall_per_req = 0; rsp_lat = 0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < hs_idx.size(); i++) if (hs_idx[i] !== i % N) bad++;
    checks++; if (bad !== 0) $display("FAIL b2b_order_midstep: %0d violations want 0", bad); else passed++;
    checks++; if (hs_cnt - h0 !== 8 * N || unstable !== 0) $display("FAIL b2b_handshakes: hs=%0d unstable=%0d want %0d/0", hs_cnt - h0, unstable, 8 * N); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_backpressure();
    test_overrun();
    test_auto_tick();
    test_reset_mid_step();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
